datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_if.sv | 33 +++
 rtl/datapath_ctrl.sv | 163 ++++++++++++++++
 tb/tb_datapath_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_if.sv
// Handshake and control bundle between the instruction sequencer and the datapath.
// The slave side is the controller; the master side issues instructions and consumes controls.
interface datapath_ctrl_if;
  logic        start;
  logic [15:0] instr;
  logic        ready;
  logic        illegal;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  modport slave (
    input  start, instr,
    output ready, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads,
           readnum, writenum, shift, ALUop, datapath_in
  );

  modport master (
    output start, instr,
    input  ready, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads,
           readnum, writenum, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/datapath_ctrl.sv
// Multi-cycle instruction sequencer: latches instr on start in WAIT, then steps Moore states.
// Latency 1 (illegal) to 5 (ADD/AND) cycles; start is ignored whenever ready is low.
module datapath_ctrl (
  input logic            clk,
  input logic            rst_n,
  datapath_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    DECODE = 3'd1,
    WIMM   = 3'd2,
    GETA   = 3'd3,
    GETB   = 3'd4,
    CALC   = 3'd5,
    WRITE  = 3'd6
  } state_t;

  state_t      state;
  state_t      next;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  logic       ready;
  logic       illegal;
  logic       write;
  logic       vsel;
  logic       loada;
  logic       loadb;
  logic       asel;
  logic       bsel;
  logic       loadc;
  logic       loads;
  logic [2:0] readnum;
  logic [2:0] writenum;
  logic [1:0] shift;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
    end else begin
      state <= next;
    end
  end

  // IR only loads on an accepted start, so later start pulses cannot disturb decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= 16'h0000;
    end else if (state == WAIT && bus.start) begin
      ir <= bus.instr;
    end
  end

  always_comb begin
    next     = state;
    ready    = 1'b0;
    illegal  = 1'b0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    shift    = 2'd0;
    alu_op   = 2'd0;

    case (state)
      WAIT: begin
        ready = 1'b1;
        if (bus.start) next = DECODE;
      end
      DECODE: begin
        if (opcode == 3'b110 && op == 2'b10) begin
          next = WIMM;
        end else if (opcode == 3'b110 && op == 2'b00) begin
          next = GETB;
        end else if (opcode == 3'b101) begin
          next = (op == 2'b11) ? GETB : GETA;
        end else begin
          illegal = 1'b1;
          next    = WAIT;
        end
      end
      WIMM: begin
        vsel     = 1'b1;
        write    = 1'b1;
        writenum = rn;
        next     = WAIT;
      end
      GETA: begin
        readnum = rn;
        loada   = 1'b1;
        next    = GETB;
      end
      GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        next    = CALC;
      end
      CALC: begin
        loadc = 1'b1;
        shift = sh;
        // MOV reg passes B through an adder with A zeroed; MVN keeps asel low.
        if (opcode == 3'b110) begin
          asel   = 1'b1;
          alu_op = 2'b00;
        end else begin
          alu_op = op;
        end
        if (opcode == 3'b101 && op == 2'b01) begin
          loads = 1'b1;
          next  = WAIT;
        end else begin
          next = WRITE;
        end
      end
      WRITE: begin
        write    = 1'b1;
        writenum = rd;
        next     = WAIT;
      end
      default: begin
        next = WAIT;
      end
    endcase
  end

  assign bus.ready       = ready;
  assign bus.illegal     = illegal;
  assign bus.write       = write;
  assign bus.vsel        = vsel;
  assign bus.loada       = loada;
  assign bus.loadb       = loadb;
  assign bus.asel        = asel;
  assign bus.bsel        = bsel;
  assign bus.loadc       = loadc;
  assign bus.loads       = loads;
  assign bus.readnum     = readnum;
  assign bus.writenum    = writenum;
  assign bus.shift       = shift;
  assign bus.ALUop       = alu_op;
  assign bus.datapath_in = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl: one expected control word per cycle, hand-derived from the instruction encodings.
module tb_datapath_ctrl;

  logic clk;
  logic rst_n;

  datapath_ctrl_if bus ();

  datapath_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {ready, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads, readnum, writenum, shift, ALUop}
  localparam logic [19:0] RDY = 20'h1 << 19;
  localparam logic [19:0] ILL = 20'h1 << 18;
  localparam logic [19:0] WR  = 20'h1 << 17;
  localparam logic [19:0] VS  = 20'h1 << 16;
  localparam logic [19:0] LA  = 20'h1 << 15;
  localparam logic [19:0] LB  = 20'h1 << 14;
  localparam logic [19:0] AS  = 20'h1 << 13;
  localparam logic [19:0] LC  = 20'h1 << 11;
  localparam logic [19:0] LS  = 20'h1 << 10;

  function automatic logic [19:0] rn(input logic [2:0] n);
    return {10'b0, n, 7'b0};
  endfunction
  function automatic logic [19:0] wn(input logic [2:0] n);
    return {13'b0, n, 4'b0};
  endfunction
  function automatic logic [19:0] sh(input logic [1:0] s);
    return {16'b0, s, 2'b0};
  endfunction
  function automatic logic [19:0] al(input logic [1:0] a);
    return {18'b0, a};
  endfunction

  logic [19:0] ctl;
  assign ctl = {bus.ready, bus.illegal, bus.write, bus.vsel, bus.loada, bus.loadb,
                bus.asel, bus.bsel, bus.loadc, bus.loads, bus.readnum, bus.writenum,
                bus.shift, bus.ALUop};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [19:0] exp);
    @(posedge clk);
    #2;
    check(tag, 32'(ctl), 32'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.instr = 16'hFFFF;
    #2;
    check("rst_ctl", 32'(ctl), 32'(RDY));
    check("rst_dpin", 32'(bus.datapath_in), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc("idle0", RDY);
    cyc("idle1", RDY);

    // MOV R2,#7 with the live bus changed after capture
    bus.start = 1'b1; bus.instr = 16'hD207;
    cyc("movi_dec", 20'h0);
    bus.start = 1'b0; bus.instr = 16'hE000;
    cyc("movi_wimm", WR | VS | wn(3'd2));
    check("movi_dpin", 32'(bus.datapath_in), 32'h0007);
    cyc("movi_done", RDY);

    // MOV R1,#-8
    bus.start = 1'b1; bus.instr = 16'hD1F8;
    cyc("movn_dec", 20'h0);
    bus.start = 1'b0;
    cyc("movn_wimm", WR | VS | wn(3'd1));
    check("movn_dpin", 32'(bus.datapath_in), 32'hFFF8);
    cyc("movn_done", RDY);

    // ADD R2,R0,R0,LSL#1 with start held and instr changed mid-flight
    bus.start = 1'b1; bus.instr = 16'hA048;
    cyc("add_dec", 20'h0);
    bus.instr = 16'hD207;
    cyc("add_geta", LA | rn(3'd0));
    cyc("add_getb", LB | rn(3'd0));
    cyc("add_calc", LC | sh(2'd1) | al(2'd0));
    check("add_ir_kept", 32'(bus.datapath_in), 32'h0048);
    bus.start = 1'b0;
    cyc("add_write", WR | wn(3'd2));
    cyc("add_done", RDY);

    // CMP R1,R1
    bus.start = 1'b1; bus.instr = 16'hA901;
    cyc("cmp_dec", 20'h0);
    bus.start = 1'b0;
    cyc("cmp_geta", LA | rn(3'd1));
    cyc("cmp_getb", LB | rn(3'd1));
    cyc("cmp_calc", LC | LS | al(2'd1));
    cyc("cmp_done", RDY);

    // MOV R5,R3,LSR
    bus.start = 1'b1; bus.instr = 16'hC0B3;
    cyc("movr_dec", 20'h0);
    bus.start = 1'b0;
    cyc("movr_getb", LB | rn(3'd3));
    cyc("movr_calc", LC | AS | sh(2'd2));
    cyc("movr_write", WR | wn(3'd5));
    cyc("movr_done", RDY);

    // MVN R7,R1
    bus.start = 1'b1; bus.instr = 16'hB8E1;
    cyc("mvn_dec", 20'h0);
    bus.start = 1'b0;
    cyc("mvn_getb", LB | rn(3'd1));
    cyc("mvn_calc", LC | al(2'd3));
    cyc("mvn_write", WR | wn(3'd7));
    cyc("mvn_done", RDY);

    // unsupported opcode, then unsupported op within opcode 110
    bus.start = 1'b1; bus.instr = 16'hE000;
    cyc("ill_dec", ILL);
    bus.start = 1'b0;
    cyc("ill_done", RDY);
    bus.start = 1'b1; bus.instr = 16'hC800;
    cyc("ill2_dec", ILL);
    bus.start = 1'b0;
    cyc("ill2_done", RDY);

    // back-to-back with start held high
    bus.start = 1'b1; bus.instr = 16'hD207;
    cyc("b2b_dec0", 20'h0);
    cyc("b2b_wimm0", WR | VS | wn(3'd2));
    cyc("b2b_wait", RDY);
    cyc("b2b_dec1", 20'h0);
    bus.start = 1'b0;
    cyc("b2b_wimm1", WR | VS | wn(3'd2));
    cyc("b2b_done", RDY);

    // reset during GETB of an ADD, then resume with start held
    bus.start = 1'b1; bus.instr = 16'hA048;
    cyc("rab_dec", 20'h0);
    bus.start = 1'b0;
    cyc("rab_geta", LA | rn(3'd0));
    cyc("rab_getb", LB | rn(3'd0));
    #1 rst_n = 1'b0;
    #1;
    check("rab_async", 32'(ctl), 32'(RDY));
    check("rab_dpin", 32'(bus.datapath_in), 32'h0);
    bus.start = 1'b1; bus.instr = 16'hD1F8;
    cyc("rab_hold", RDY);
    rst_n = 1'b1;
    cyc("rab_dec2", 20'h0);
    bus.start = 1'b0;
    cyc("rab_wimm", WR | VS | wn(3'd1));
    check("rab_wdpin", 32'(bus.datapath_in), 32'hFFF8);
    cyc("rab_done", RDY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
